// File: rtl/att_pkg.sv
// att_pkg: shared FSM state encoding and default sizing for the attenuator SPI controller
package att_pkg;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NUM_CS  = 8;
  localparam int DEF_CLK_DIV = 1;
  typedef enum logic [2:0] {
    IDLE, SELECT, CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD, GAP, FINISH
  } att_state_e;
endpackage

// File: rtl/att_spi_clkdiv.sv
// att_spi_clkdiv: half-period tick generator for the SPI serial clock
//   clk, reset      : clock, asynchronous active-high reset
//   run             : count while high, counter held at zero while low
//   short_phase     : end this phase one cycle early (CLK_DIV cycles instead of CLK_DIV+1)
//   tick            : one-cycle strobe on the last cycle of the current phase
module att_spi_clkdiv
  import att_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic short_phase,
  output logic tick
);
  localparam int CW = CLK_DIV > 0 ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [CW-1:0] TC_FULL  = CW'(CLK_DIV);
  localparam logic [CW-1:0] TC_SHORT = CW'(CLK_DIV > 0 ? CLK_DIV - 1 : 0);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = run && cnt_q == (short_phase ? TC_SHORT : TC_FULL);
    cnt_d = (!run || tick) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/att_spi_ctrl.sv
// att_spi_ctrl: serial programming of step attenuators over a shared SCLK/SDATA bus
//   clk, reset        : clock, asynchronous active-high reset
//   start             : one-cycle request, accepted only when idle and soft_rst low
//   att_data, cs_mask : word to send and devices to program, latched on accepted start
//   soft_rst          : level abort back to idle, blocks new starts while high
//   spi_sclk/sdata    : serial clock (idle low) and MSB-first data
//   spi_cs_n          : active-low chip selects
//   busy, done        : sequence in progress, one-cycle normal-completion pulse
//   ATT_SPI_BROADCAST_EN: when defined, all selected devices share one transfer
module att_spi_ctrl
  import att_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_CS  = DEF_NUM_CS,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] att_data,
  input  logic [NUM_CS-1:0] cs_mask,
  input  logic              soft_rst,
  output logic              spi_sclk,
  output logic              spi_sdata,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              busy,
  output logic              done
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] MSB = BW'(DATA_W - 1);
  att_state_e state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NUM_CS-1:0] mask_q, mask_d, sel_q, sel_d, cs_n_q, cs_n_d, pick, left;
  logic [BW-1:0] bit_q, bit_d;
  logic sclk_q, sclk_d, sdata_q, sdata_d, busy_q, busy_d, done_q, done_d;
  logic tick, run, leave;
  att_spi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .short_phase (state_q == GAP),
    .tick        (tick)
  );
`ifdef ATT_SPI_BROADCAST_EN
  assign pick = mask_q;
`else
  assign pick = mask_q & (~mask_q + NUM_CS'(1));
`endif
  assign run  = state_q inside {CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD, GAP};
  assign left = mask_q & ~sel_q;
  // SELECT occupies one cs-high cycle, so GAP is one cycle short to keep the
  // all-high interval and the per-device time exact; with CLK_DIV=0 GAP vanishes.
  assign leave = tick && (state_q == GAP || (state_q == CS_HOLD && CLK_DIV == 0));
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    bit_d   = bit_q;
    sdata_d = sdata_q;
    case (state_q)
      IDLE: if (start && !soft_rst) begin
        data_d  = att_data;
        mask_d  = cs_mask;
        state_d = |cs_mask ? SELECT : FINISH;
      end
      SELECT: begin
        sel_d   = pick;
        bit_d   = MSB;
        sdata_d = data_q[DATA_W-1];
        state_d = |mask_q ? CS_SETUP : FINISH;
      end
      CS_SETUP: state_d = tick ? SHIFT_LO : state_q;
      SHIFT_LO: state_d = tick ? SHIFT_HI : state_q;
      SHIFT_HI: if (tick) begin
        state_d = bit_q == '0 ? CS_HOLD : SHIFT_LO;
        bit_d   = bit_q == '0 ? bit_q : bit_q - BW'(1);
        sdata_d = data_q[bit_d];
      end
      CS_HOLD: state_d = tick ? GAP : state_q;
      GAP:     state_d = state_q;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (leave) begin
      mask_d  = left;
      state_d = |left ? SELECT : FINISH;
    end
    if (soft_rst) state_d = IDLE;
    sclk_d = state_d == SHIFT_HI;
    cs_n_d = state_d inside {CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD} ? ~sel_d : '1;
    busy_d = state_d != IDLE;
    done_d = state_d == FINISH;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      cs_n_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign spi_sclk  = sclk_q;
  assign spi_sdata = sdata_q;
  assign spi_cs_n  = cs_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_att_spi_ctrl.sv
// tb_att_spi_ctrl: scoreboard bench for att_spi_ctrl against a transfer-level model
module tb_att_spi_ctrl;
  localparam int DW = 8;
  localparam int NC = 8;
  localparam int CD = 1;
  localparam int DEV_T = (2 * DW + 3) * (CD + 1);
  localparam int LOW_T = (2 * DW + 2) * (CD + 1);
  typedef struct packed {
    logic [NC-1:0] cs;
    logic [DW-1:0] w;
  } xfer_t;
  logic clk = 0, reset = 1, start = 0, soft_rst = 0;
  logic [DW-1:0] att_data = '0;
  logic [NC-1:0] cs_mask = '0;
  logic spi_sclk, spi_sdata, busy, done;
  logic [NC-1:0] spi_cs_n;
  int checks = 0, passed = 0, stray = 0;
  longint cyc = 0, acc_cyc = -1, end_cyc = -1;
  xfer_t xq[$];
  longint dq[$];
  bit drop = 0;
  att_spi_ctrl #(.DATA_W(DW), .NUM_CS(NC), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .start(start), .att_data(att_data), .cs_mask(cs_mask),
    .soft_rst(soft_rst), .spi_sclk(spi_sclk), .spi_sdata(spi_sdata), .spi_cs_n(spi_cs_n),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: got unexpected event, required none (cycle %0d)", name, cyc);
  endtask
  // Model: a request is taken only when the previous sequence's done cycle has passed;
  // each selected device costs one device-time, done one cycle after start plus that.
  task automatic issue(input logic [DW-1:0] d, input logic [NC-1:0] m);
    int n;
    @(posedge clk);
    #1;
    att_data = d;
    cs_mask  = m;
    start    = 1;
    if (!soft_rst && cyc > end_cyc) begin
      n = 0;
`ifdef ATT_SPI_BROADCAST_EN
      if (m != 0) begin
        xq.push_back('{~m, d});
        n = 1;
      end
`else
      for (int i = 0; i < NC; i++)
        if (m[i]) begin
          xq.push_back('{~(NC'(1) << i), d});
          n++;
        end
`endif
      acc_cyc = cyc;
      end_cyc = cyc + 1 + n * DEV_T;
      dq.push_back(end_cyc);
    end
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic settle();
    while (cyc <= end_cyc) @(posedge clk);
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask
  initial begin : monitor
    bit in_x;
    logic prev_sclk;
    logic [NC-1:0] x_cs;
    logic [DW-1:0] word;
    int edges, low_n;
    bit cs_bad;
    xfer_t e;
    in_x = 0;
    prev_sclk = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_x = 0;
        prev_sclk = 0;
      end else begin
        chk("busy", busy, (cyc > acc_cyc && cyc <= end_cyc));
        if (spi_cs_n != '1) begin
          if (!in_x) begin
            in_x = 1;
            x_cs = spi_cs_n;
            word = '0;
            edges = 0;
            low_n = 0;
            cs_bad = 0;
          end
          low_n++;
          if (spi_cs_n != x_cs) cs_bad = 1;
          if (spi_sclk && !prev_sclk) begin
            word = {word[DW-2:0], spi_sdata};
            edges++;
          end
        end else begin
          if (in_x) begin
            in_x = 0;
            if (drop) drop = 0;
            else if (xq.size() == 0) fail("xfer_extra");
            else begin
              e = xq.pop_front();
              chk("xfer_cs_n", x_cs, e.cs);
              chk("xfer_word", word, e.w);
              chk("xfer_edges", edges, DW);
              chk("xfer_cs_low_cycles", low_n, LOW_T);
              chk("xfer_cs_stable", cs_bad, 0);
            end
          end
          if (spi_sclk && !prev_sclk) stray++;
        end
        if (done) begin
          if (dq.size() == 0) fail("done_extra");
          else chk("done_cycle", cyc, dq.pop_front());
        end
        prev_sclk = spi_sclk;
      end
    end
  end
  initial begin : stim
    int k, ed;
    logic p;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", spi_cs_n, {NC{1'b1}});
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_sdata", spi_sdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 0;
    issue(8'h5A, 8'h05);
    settle();
    issue(8'h00, 8'h00);
    settle();
    issue(8'h5A, 8'h05);
    repeat (9) @(posedge clk);
    issue(8'hFF, 8'hFF);
    settle();
    for (int it = 0; it < 25; it++) begin
      issue(DW'($urandom), ($urandom_range(0, 4) == 0) ? '0 : NC'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
        issue(DW'($urandom), NC'($urandom));
      end
      settle();
    end
    issue(8'hC3, 8'h81);
    k = 0;
    ed = 0;
    p = 0;
    while (ed < 4 && k < 300) begin
      @(negedge clk);
      if (spi_sclk && !p) ed++;
      p = spi_sclk;
      k++;
    end
    if (ed < 4) fail("wait_bit4_timeout");
    drop = 1;
    xq.delete();
    dq.delete();
    end_cyc = cyc;
    soft_rst = 1;
    @(posedge clk);
    #1;
    chk("softrst_cs_n", spi_cs_n, {NC{1'b1}});
    chk("softrst_sclk", spi_sclk, 0);
    chk("softrst_busy", busy, 0);
    issue(8'h33, 8'h02);
    @(posedge clk);
    #1;
    soft_rst = 0;
    repeat (2) @(posedge clk);
    issue(8'h96, 8'h12);
    settle();
    issue(8'hA5, 8'h40);
    k = 0;
    while (!spi_sclk && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!spi_sclk) fail("wait_shift_hi_timeout");
    #2;
    reset = 1;
    #1;
    chk("arst_cs_n", spi_cs_n, {NC{1'b1}});
    chk("arst_sclk", spi_sclk, 0);
    chk("arst_sdata", spi_sdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    xq.delete();
    dq.delete();
    drop = 0;
    end_cyc = cyc;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    issue(8'h5A, 8'h05);
    settle();
    k = 0;
    while (dq.size() > 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    chk("done_queue_empty", dq.size(), 0);
    chk("xfer_queue_empty", xq.size(), 0);
    chk("stray_sclk_edges", stray, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/att_spi_ctrl.md
ATT_SPI_CTRL -- requirements
Module: att_spi_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, attenuator serial word width.
REQ-002 SHALL have parameter NUM_CS, default 8, number of attenuator chip selects.
REQ-003 SHALL have parameter CLK_DIV, default 1; SCLK half-period is CLK_DIV+1 clk cycles.
REQ-004 SHALL have port clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request (driven by the ATT_DATA write strobe).
REQ-007 SHALL have port att_data, input, DATA_W, word to transmit.
REQ-008 SHALL have port cs_mask, input, NUM_CS, devices to program (bit i = device i).
REQ-009 SHALL have port soft_rst, input, 1, level abort from the ATT_RESET register bit 0.
REQ-010 SHALL have port spi_sclk, output, 1, serial clock, idle low.
REQ-011 SHALL have port spi_sdata, output, 1, serial data, MSB first.
REQ-012 SHALL have port spi_cs_n, output, NUM_CS, active-low chip selects.
REQ-013 SHALL have port busy, output, 1, high while a transfer sequence runs.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when a sequence completes normally.

Function
REQ-015 SHALL accept start only in IDLE with soft_rst low; start while busy SHALL be ignored.
REQ-016 SHALL latch att_data and cs_mask on the accepted start cycle; later input changes SHALL NOT affect the sequence.
REQ-017 SHALL assert busy the cycle after an accepted start and hold it until the cycle done pulses.
REQ-018 SHALL use states IDLE, SELECT, CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD, GAP, FINISH.
REQ-019 SELECT SHALL pick the lowest-index remaining mask bit; none remaining -> FINISH.
REQ-020 CS_SETUP: the selected cs_n low, sclk low, sdata = bit DATA_W-1, for CLK_DIV+1 cycles.
REQ-021 SHIFT_LO/SHIFT_HI: sclk low then high, each CLK_DIV+1 cycles, per bit; sdata changes only on entry to SHIFT_LO (falling edge), DATA_W rising edges total.
REQ-022 CS_HOLD: sclk low, cs_n still low, CLK_DIV+1 cycles; GAP: all cs_n high, CLK_DIV+1 cycles; then clear the serviced mask bit and return to SELECT.
REQ-023 Per-device transfer SHALL take (2*DATA_W+3)*(CLK_DIV+1) cycles (38 at defaults).
REQ-024 FINISH SHALL pulse done for one cycle, deassert busy, return to IDLE.
REQ-025 A latched mask of zero SHALL produce done one cycle after start with no sclk or cs_n activity.
REQ-026 At most one cs_n bit SHALL be low at any time (unless REQ-031).
REQ-027 soft_rst high in any state SHALL within one cycle force IDLE, sclk low, all cs_n high, busy low, no done pulse, and block new starts while high.
REQ-028 Bit and divider counters SHALL be sized with $clog2 and SHALL not wrap within a device transfer.

Reset
REQ-029 On reset: state IDLE, spi_sclk 0, spi_sdata 0, spi_cs_n all ones, busy 0, done 0, latched data/mask zero; reset mid-transfer aborts immediately with no done.

Configuration
REQ-030 Macro ATT_SPI_BROADCAST_EN SHALL select broadcast mode when defined.
REQ-031 With ATT_SPI_BROADCAST_EN defined: all latched mask bits driven low together in one transfer, one device-time per sequence; without it: sequential per REQ-019..REQ-026.

Structure
REQ-032 State encoding typedef and default DATA_W/NUM_CS/CLK_DIV constants SHALL live in the shared att_pkg package.
REQ-033 SCLK timing SHALL be a sub-module att_spi_clkdiv producing half-period tick strobes; FSM stays in att_spi_ctrl.

Verification
REQ-034 Defaults, data=0x5A, mask=0x05, start -> cs_n[0] then cs_n[2] low, each sees 8 rising edges with bits 0,1,0,1,1,0,1,0; done 76 cycles after busy rises.
REQ-035 mask=0x00, start -> done exactly one cycle after start; sclk and cs_n never toggle.
REQ-036 Second start 10 cycles into a transfer, plus att_data changed to 0xFF -> ignored; transmitted word stays 0x5A; single done.
REQ-037 soft_rst pulsed during bit 4 of device 0 -> next cycle all cs_n high, sclk low, busy low; no done; later start after soft_rst low runs normally.
REQ-038 Async reset asserted mid-SHIFT_HI -> outputs reach reset values without a clock edge.
REQ-039 ATT_SPI_BROADCAST_EN defined, mask=0x05 -> cs_n[0] and cs_n[2] low together, 8 edges, done after 38 cycles.
